// File: rtl/card_glyph_pkg.sv
// Shared glyph codes, card constants and FSM state encoding for the card glyph decoder.
package card_glyph_pkg;

  localparam int GLYPH_BLANK = 24;
  localparam int GLYPH_A     = 13;
  localparam int GLYPH_J     = 10;
  localparam int GLYPH_K_L   = 12;
  localparam int GLYPH_K_R   = 23;
  localparam int GLYPH_Q_T   = 22;
  localparam int GLYPH_I     = 15;
  localparam int GLYPH_H     = 16;
  localparam int GLYPH_E     = 17;
  localparam int GLYPH_C     = 18;
  localparam int GLYPH_S     = 20;
  localparam int GLYPH_P     = 21;

  localparam int NUM_CARDS    = 52;
  localparam int NUM_RANKS    = 13;
  localparam int CARD_INVALID = 63;

  typedef enum logic [2:0] {
    S_D1  = 3'd0,
    S_D2  = 3'd1,
    S_D3  = 3'd2,
    S_D4  = 3'd3,
    S_OUT = 3'd4
  } state_t;

endpackage

// File: rtl/card_glyph_decoder_if.sv
// Glyph input stream and card output stream of the card glyph decoder.
// Optional CARD_DUP_DETECT_EN adds card_dup / dup_clear.
interface card_glyph_decoder_if #(
  parameter int GLYPH_W = 5,
  parameter int CARD_W  = 6
);
  logic [GLYPH_W-1:0] glyph_in;
  logic               glyph_valid;
  logic               glyph_ready;
  logic               flush;
  logic [CARD_W-1:0]  card;
  logic               card_err;
  logic               card_valid;
  logic               card_ready;
  logic               timeout;
`ifdef CARD_DUP_DETECT_EN
  logic               card_dup;
  logic               dup_clear;
`endif

  modport slave (
    input  glyph_in, glyph_valid, flush, card_ready,
    output glyph_ready, card, card_err, card_valid, timeout
`ifdef CARD_DUP_DETECT_EN
    , input dup_clear, output card_dup
`endif
  );

  modport master (
    output glyph_in, glyph_valid, flush, card_ready,
    input  glyph_ready, card, card_err, card_valid, timeout
`ifdef CARD_DUP_DETECT_EN
    , output dup_clear, input card_dup
`endif
  );
endinterface

// File: rtl/glyph_pair_lookup.sv
// Combinational decode of (dig1,dig2) into a rank and (dig3,dig4) into a suit.
module glyph_pair_lookup
  import card_glyph_pkg::*;
#(
  parameter int GLYPH_W = 5
) (
  input  logic [GLYPH_W-1:0] dig1,
  input  logic [GLYPH_W-1:0] dig2,
  input  logic [GLYPH_W-1:0] dig3,
  input  logic [GLYPH_W-1:0] dig4,
  output logic [3:0]         rank,
  output logic [1:0]         suit,
  output logic               rank_bad,
  output logic               suit_bad
);

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    rank     = '0;
    rank_bad = 1'b0;
    if (dig1 == GLYPH_W'(GLYPH_A) && dig2 == GLYPH_W'(GLYPH_BLANK))
      rank = 4'd0;
    else if (dig1 >= GLYPH_W'(2) && dig1 <= GLYPH_W'(9) && dig2 == GLYPH_W'(GLYPH_BLANK))
      rank = 4'(dig1 - GLYPH_W'(1));
    else if (dig1 == GLYPH_W'(1) && dig2 == GLYPH_W'(0))
      rank = 4'd9;
    else if (dig1 == GLYPH_W'(GLYPH_J) && dig2 == GLYPH_W'(GLYPH_BLANK))
      rank = 4'd10;
    else if (dig1 == GLYPH_W'(0) && dig2 == GLYPH_W'(GLYPH_Q_T))
      rank = 4'd11;
    else if (dig1 == GLYPH_W'(GLYPH_K_L) && dig2 == GLYPH_W'(GLYPH_K_R))
      rank = 4'd12;
    else
      rank_bad = 1'b1;
  end

  always_comb begin
    suit     = '0;
    suit_bad = 1'b0;
    if (dig3 == GLYPH_W'(0) && dig4 == GLYPH_W'(GLYPH_I))
      suit = 2'd0;
    else if (dig3 == GLYPH_W'(GLYPH_H) && dig4 == GLYPH_W'(GLYPH_E))
      suit = 2'd1;
    else if (dig3 == GLYPH_W'(GLYPH_C) && dig4 == GLYPH_W'(1))
      suit = 2'd2;
    else if (dig3 == GLYPH_W'(GLYPH_S) && dig4 == GLYPH_W'(GLYPH_P))
      suit = 2'd3;
    else
      suit_bad = 1'b1;
  end

endmodule

// File: rtl/card_glyph_decoder.sv
// Reassembles four serial display glyphs into a card index 0..51 with error flag.
// Optional CARD_DUP_DETECT_EN tracks already-delivered cards and flags repeats.
module card_glyph_decoder
  import card_glyph_pkg::*;
#(
  parameter int GLYPH_W        = 5,
  parameter int CARD_W         = 6,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic                  clk,
  input logic                  rst_n,
  card_glyph_decoder_if.slave  bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state;
  logic [GLYPH_W-1:0] g1, g2, g3;
  logic [CNT_W-1:0]   idle_cnt;
  logic [CARD_W-1:0]  card_q;
  logic               card_err_q, card_valid_q, timeout_q;
  logic [3:0]         rank;
  logic [1:0]         suit;
  logic               rank_bad, suit_bad, decode_bad;
  logic [CARD_W-1:0]  card_next;
  logic               accept, handshake;

  // The fourth glyph is decoded straight off the bus on its accept edge.
  glyph_pair_lookup #(.GLYPH_W(GLYPH_W)) u_lookup (
    .dig1(g1), .dig2(g2), .dig3(g3), .dig4(bus.glyph_in),
    .rank(rank), .suit(suit), .rank_bad(rank_bad), .suit_bad(suit_bad)
  );

  assign decode_bad = rank_bad | suit_bad;
  assign card_next  = decode_bad ? CARD_W'(CARD_INVALID)
                                 : CARD_W'(suit) * CARD_W'(NUM_RANKS) + CARD_W'(rank);
  assign accept     = bus.glyph_valid & bus.glyph_ready;
  assign handshake  = card_valid_q & bus.card_ready;

  assign bus.glyph_ready = (state != S_OUT);
  assign bus.card        = card_q;
  assign bus.card_err    = card_err_q;
  assign bus.card_valid  = card_valid_q;
  assign bus.timeout     = timeout_q;

`ifdef CARD_DUP_DETECT_EN
  logic [NUM_CARDS-1:0] seen;
  logic                 dup_q;
  logic                 dup_next;

  assign dup_next     = !decode_bad && (card_next < CARD_W'(NUM_CARDS)) && seen[card_next];
  assign bus.card_dup = dup_q;

  // NOTE: the mask is a handful of flops, not a RAM, so it takes the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      seen <= '0;
    else if (bus.dup_clear)
      seen <= '0;
    else if (!bus.flush && state == S_OUT && handshake && !card_err_q)
      seen[card_q] <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dup_q <= 1'b0;
    else if (bus.flush)
      dup_q <= 1'b0;
    else if (state == S_D4 && accept)
      dup_q <= dup_next;
  end
`endif

  // NOTE: all state here uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_D1;
      g1           <= GLYPH_W'(GLYPH_BLANK);
      g2           <= GLYPH_W'(GLYPH_BLANK);
      g3           <= GLYPH_W'(GLYPH_BLANK);
      idle_cnt     <= '0;
      card_q       <= CARD_W'(CARD_INVALID);
      card_err_q   <= 1'b0;
      card_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else if (bus.flush) begin
      state        <= S_D1;
      idle_cnt     <= '0;
      card_q       <= CARD_W'(CARD_INVALID);
      card_err_q   <= 1'b0;
      card_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        S_D1, S_D2, S_D3, S_D4: begin
          if (accept) begin
            idle_cnt <= '0;
            case (state)
              S_D1:    begin g1 <= bus.glyph_in; state <= S_D2; end
              S_D2:    begin g2 <= bus.glyph_in; state <= S_D3; end
              S_D3:    begin g3 <= bus.glyph_in; state <= S_D4; end
              default: begin
                state        <= S_OUT;
                card_q       <= card_next;
                card_err_q   <= decode_bad;
                card_valid_q <= 1'b1;
              end
            endcase
          end else if (TO_EN && state != S_D1) begin
            if (idle_cnt == CNT_LAST) begin
              state     <= S_D1;
              idle_cnt  <= '0;
              timeout_q <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        S_OUT: begin
          if (handshake) begin
            state        <= S_D1;
            card_valid_q <= 1'b0;
          end
        end
        default: state <= S_D1;
      endcase
    end
  end

endmodule

// File: tb/tb_card_glyph_decoder.sv
// Self-checking bench for card_glyph_decoder: directed cases plus randomized entries
// checked against a table-driven card model. Define CARD_DUP_DETECT_EN to cover card_dup.
module tb_card_glyph_decoder;

  localparam int GLYPH_W = 5;
  localparam int CARD_W  = 6;
  localparam int TO_CYC  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  card_glyph_decoder_if #(.GLYPH_W(GLYPH_W), .CARD_W(CARD_W)) bus ();

  card_glyph_decoder #(.GLYPH_W(GLYPH_W), .CARD_W(CARD_W), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Glyph spellings of each rank and suit, indexed by value.
  int rank_d1 [13] = '{13, 2, 3, 4, 5, 6, 7, 8, 9, 1, 10, 0, 12};
  int rank_d2 [13] = '{24, 24, 24, 24, 24, 24, 24, 24, 24, 0, 24, 22, 23};
  int suit_d3 [4]  = '{0, 16, 18, 20};
  int suit_d4 [4]  = '{15, 17, 1, 21};
  bit seen [52];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void ref_decode(input int g[4], output int card, output bit err);
    int r = -1, s = -1;
    for (int i = 0; i < 13; i++)
      if (g[0] == rank_d1[i] && g[1] == rank_d2[i]) r = i;
    for (int i = 0; i < 4; i++)
      if (g[2] == suit_d3[i] && g[3] == suit_d4[i]) s = i;
    err  = (r < 0) || (s < 0);
    card = err ? 63 : s * 13 + r;
  endfunction

  // Called at a negedge; returns at the negedge after the glyph was accepted.
  task automatic put_glyph(int g, int gap);
    repeat (gap) @(negedge clk);
    bus.glyph_in    = GLYPH_W'(g);
    bus.glyph_valid = 1'b1;
    @(negedge clk);
    bus.glyph_valid = 1'b0;
  endtask

  task automatic put_entry(int g[4]);
    for (int i = 0; i < 4; i++) put_glyph(g[i], 0);
  endtask

  task automatic check_card(string tag, int g[4]);
    int  c;
    bit  e;
    ref_decode(g, c, e);
    check({tag, "_valid"}, bus.card_valid, 1);
    check({tag, "_card"}, bus.card, c);
    check({tag, "_err"}, bus.card_err, e);
  endtask

  task automatic take_card(string tag, int hold, int exp_card);
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_card"}, bus.card, exp_card);
      check({tag, "_hold_gready"}, bus.glyph_ready, 0);
      check({tag, "_hold_valid"}, bus.card_valid, 1);
      @(negedge clk);
    end
    bus.card_ready = 1'b1;
    @(negedge clk);
    bus.card_ready = 1'b0;
    check({tag, "_rel_valid"}, bus.card_valid, 0);
    check({tag, "_rel_gready"}, bus.glyph_ready, 1);
  endtask

  initial begin
    int g[4];
    int c, hit, gap, hold;
    bit e;

    bus.glyph_in = '0; bus.glyph_valid = 1'b0; bus.flush = 1'b0; bus.card_ready = 1'b0;
`ifdef CARD_DUP_DETECT_EN
    bus.dup_clear = 1'b0;
`endif
    @(negedge clk);
    check("rst_gready", bus.glyph_ready, 1);
    check("rst_card", bus.card, 63);
    check("rst_err", bus.card_err, 0);
    check("rst_valid", bus.card_valid, 0);
    check("rst_timeout", bus.timeout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ace of diamonds with consumer always ready: valid for exactly one cycle.
    bus.card_ready = 1'b1;
    g = '{13, 24, 0, 15};
    put_entry(g);
    check_card("ace_di", g);
    @(negedge clk);
    check("ace_di_drop", bus.card_valid, 0);
    bus.card_ready = 1'b0;

    // King of spades with back-pressure.
    g = '{12, 23, 20, 21};
    put_entry(g);
    check_card("k_sp", g);
    take_card("k_sp", 5, 51);

    g = '{1, 0, 18, 1};   put_entry(g); check_card("ten_cl", g); take_card("ten_cl", 0, 35);
    g = '{7, 24, 16, 17}; put_entry(g); check_card("six_he", g); take_card("six_he", 0, 19);
    g = '{11, 24, 0, 15}; put_entry(g); check_card("bad_rank", g); take_card("bad_rank", 0, 63);
    g = '{5, 24, 20, 15}; put_entry(g); check_card("bad_suit", g); take_card("bad_suit", 0, 63);
    g = '{31, 24, 0, 15}; put_entry(g); check_card("hi_glyph", g); take_card("hi_glyph", 0, 63);

    // Timeout after two glyphs and four idle cycles.
    put_glyph(13, 0);
    put_glyph(24, 0);
    hit = 0;
    for (int i = 1; i <= 8 && hit == 0; i++) begin
      @(negedge clk);
      if (bus.timeout) hit = i;
    end
    check("timeout_cycle", hit, TO_CYC);
    @(negedge clk);
    check("timeout_pulse", bus.timeout, 0);
    g = '{13, 24, 16, 17}; put_entry(g); check_card("after_to", g); take_card("after_to", 0, 13);

    // Three idle cycles must not time out.
    put_glyph(13, 0);
    put_glyph(24, 3);
    check("no_timeout", bus.timeout, 0);
    put_glyph(0, 3);
    put_glyph(15, 3);
    check("slow_entry", bus.card, 0);
    take_card("slow_entry", 0, 0);

    // Flush on the third-glyph accept edge drops that glyph.
    put_glyph(12, 0);
    put_glyph(23, 0);
    bus.glyph_in = 5'd20; bus.glyph_valid = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    bus.glyph_valid = 1'b0; bus.flush = 1'b0;
    check("flush_gready", bus.glyph_ready, 1);
    check("flush_valid", bus.card_valid, 0);
    for (int i = 0; i < 3; i++) put_glyph(rank_d1[0] * (i == 0) + 24 * (i == 1), 0);
    check("flush_partial", bus.card_valid, 0);
    put_glyph(15, 0);
    g = '{13, 24, 0, 15};
    check_card("flush_full", g);
    take_card("flush_full", 0, 0);

    // Flush while a card is pending.
    g = '{2, 24, 0, 15}; put_entry(g);
    bus.flush = 1'b1; @(negedge clk); bus.flush = 1'b0;
    check("flush_out_valid", bus.card_valid, 0);
    check("flush_out_card", bus.card, 63);
    check("flush_out_gready", bus.glyph_ready, 1);

    // Reset mid-entry.
    put_glyph(13, 0);
    put_glyph(24, 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_gready", bus.glyph_ready, 1);
    check("rst_mid_card", bus.card, 63);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    g = '{9, 24, 18, 1}; put_entry(g); check_card("post_rst", g); take_card("post_rst", 0, 34);

`ifdef CARD_DUP_DETECT_EN
    bus.dup_clear = 1'b1; @(negedge clk); bus.dup_clear = 1'b0;
    g = '{13, 24, 0, 15};
    put_entry(g); check("dup_first", bus.card_dup, 0); take_card("dup_first", 0, 0);
    put_entry(g); check("dup_second", bus.card_dup, 1); take_card("dup_second", 0, 0);
    bus.dup_clear = 1'b1; @(negedge clk); bus.dup_clear = 1'b0;
    put_entry(g); check("dup_cleared", bus.card_dup, 0); take_card("dup_cleared", 0, 0);
    g = '{11, 24, 0, 15};
    put_entry(g); check("dup_err", bus.card_dup, 0); take_card("dup_err", 0, 63);
    bus.dup_clear = 1'b1; @(negedge clk); bus.dup_clear = 1'b0;
    foreach (seen[i]) seen[i] = 1'b0;
`endif

    // Randomized entries.
    for (int n = 0; n < 60; n++) begin
      int r, s;
      r = $urandom_range(0, 12);
      s = $urandom_range(0, 3);
      g = '{rank_d1[r], rank_d2[r], suit_d3[s], suit_d4[s]};
      if ($urandom_range(0, 3) == 0) g[$urandom_range(0, 3)] = $urandom_range(0, 31);
      for (int i = 0; i < 4; i++) begin
        gap = (i == 0) ? 0 : $urandom_range(0, 3);
        put_glyph(g[i], gap);
      end
      ref_decode(g, c, e);
      check_card("rnd", g);
`ifdef CARD_DUP_DETECT_EN
      check("rnd_dup", bus.card_dup, (!e && seen[c]) ? 1 : 0);
`endif
      hold = $urandom_range(0, 3);
      take_card("rnd", hold, c);
`ifdef CARD_DUP_DETECT_EN
      if (!e) seen[c] = 1'b1;
      if ($urandom_range(0, 9) == 0) begin
        bus.dup_clear = 1'b1; @(negedge clk); bus.dup_clear = 1'b0;
        foreach (seen[i]) seen[i] = 1'b0;
      end
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/card_glyph_decoder.md
Name: card_glyph_decoder

Overview:
Inverse of the card-to-glyph converter. It accepts a serial stream of four 5-bit display glyph codes (dig1, dig2, dig3, dig4 order) over a valid/ready handshake. It reassembles the card index 0..51 (suit*13 + rank) and presents it on a valid/ready output. It sits between the keypad/entry logic, which reuses display glyph codes, and the game engine, which consumes card indices.

Parameters:
GLYPH_W, 5, width of one glyph code
CARD_W, 6, width of card index
TIMEOUT_CYCLES, 1000, idle cycles allowed between glyphs of a partial entry before discard; 0 disables the timeout

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
glyph_in  in  GLYPH_W  glyph code
glyph_valid  in  1  glyph_in is valid
glyph_ready  out  1  block can accept a glyph
flush  in  1  synchronous abort of partial entry and pending output
card  out  CARD_W  decoded card index; 63 when invalid
card_err  out  1  entry did not decode to a legal card
card_valid  out  1  card/card_err are valid
card_ready  in  1  consumer accepts card
timeout  out  1  one-cycle pulse when a partial entry is discarded on timeout
Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.

Behaviour:
- Reset values: state=S_D1, glyph_ready=1, card=63, card_err=0, card_valid=0, timeout=0, idle counter=0, glyph registers=24 (blank).
- FSM states: S_D1, S_D2, S_D3, S_D4, S_OUT.
  - glyph_ready=1 in S_D1..S_D4; glyph_ready=0 in S_OUT.
  - A glyph is accepted on a clock edge where glyph_valid and glyph_ready are both high. It is stored in the slot for the current state, and the FSM advances D1->D2->D3->D4.
  - Acceptance in S_D4 -> S_OUT. card, card_err and card_valid are registered on that same edge, so latency is 1 cycle after the 4th accept.
  - In S_OUT, outputs hold stable until card_valid and card_ready are both high. On that edge the FSM returns to S_D1 and card_valid drops to 0. There is no back-to-back bypass.
- Rank decode from (dig1,dig2):
  - (13,24)=0 (ace).
  - (n,24) for n in 2..9 = n-1.
  - (1,0)=9.
  - (10,24)=10 (J).
  - (0,22)=11 (Q).
  - (12,23)=12 (K).
  - Any other pair is invalid.
- Suit decode from (dig3,dig4):
  - (0,15)=0 (DI).
  - (16,17)=1 (HE).
  - (18,1)=2 (CL).
  - (20,21)=3 (SP).
  - Any other pair is invalid.
- card = suit*13 + rank, computed at CARD_W bits; maximum value is 51 and there is no overflow. If either pair is invalid: card=63, card_err=1. card_valid still asserts and the error is consumed via the same handshake.
- Glyph codes of 25..31 are always invalid. They are still accepted; the error is flagged at decode.
- Flush:
  - A flush on any edge forces S_D1, card_valid=0, card=63, card_err=0, and clears the idle counter.
  - Flush has priority over a simultaneous glyph accept or card handshake; that glyph is dropped.
- Timeout:
  - The idle counter runs only in S_D2..S_D4 while no glyph is accepted. It resets on each accept.
  - When the counter reaches TIMEOUT_CYCLES-1, the next edge returns the FSM to S_D1 and timeout pulses for 1 cycle.
  - An accept on that same edge wins: no timeout fires and the FSM advances.
  - No timeout in S_D1 or S_OUT.
- Reset asserted mid-entry or mid-output immediately restores all reset values.

Optional Feature:
CARD_DUP_DETECT_EN:
- When defined, adds a 52-bit seen mask, output card_dup (1 bit), and input dup_clear (1 bit).
- On a successful output handshake of a legal card, that card's bit is set.
- card_dup is registered with card and is 1 when the card's bit was already set at decode.
- dup_clear zeroes the mask synchronously and has priority over a same-edge set.
- When not defined: no mask, no card_dup or dup_clear ports, identical behaviour otherwise.

Decomposition:
- Package card_glyph_pkg: glyph code constants (GLYPH_BLANK=24, GLYPH_A=13, GLYPH_J=10, GLYPH_K_L=12, GLYPH_K_R=23, GLYPH_Q_T=22, GLYPH_I=15, GLYPH_H=16, GLYPH_E=17, GLYPH_C=18, GLYPH_S=20, GLYPH_P=21), NUM_CARDS=52, NUM_RANKS=13, CARD_INVALID=63, FSM state enum.
- One combinational sub-module, glyph_pair_lookup: takes four glyphs and returns rank, suit and invalid flags. The FSM, counter and handshake stay in the top level.

Test Plan:
- Glyphs 13,24,0,15 with card_ready=1 -> card=0, card_err=0, card_valid high exactly 1 cycle after the 4th accept.
- Glyphs 12,23,20,21 with card_ready held 0 for 5 cycles -> card=51 held stable, glyph_ready=0 throughout; releases to S_D1 on the handshake.
- Glyphs 1,0,18,1 -> card=35; glyphs 7,24,16,17 -> card=19.
- Glyphs 11,24,0,15 -> card=63, card_err=1; glyphs 5,24,20,15 -> card_err=1.
- TIMEOUT_CYCLES=4, send 2 glyphs then idle -> timeout pulse after 4 idle cycles; a fresh 13,24,16,17 then decodes to 13. Flush asserted on the 3rd-glyph accept edge -> that glyph is dropped and the FSM is in S_D1.
- With CARD_DUP_DETECT_EN: decode card 0 twice -> card_dup=0 then 1; pulse dup_clear, decode card 0 again -> card_dup=0.
